dbg_mem_burst_ctl: RTL

- Sequences debug-interface memory accesses for the half-duplex debug UART.
- Owns the MEM_CTL, MEM_ADDR, MEM_DATA and MEM_CNT debug registers, decoded from the UART's dbg_addr/dbg_din/dbg_wr/dbg_rd.
- Drives a one-master memory request port and generates the UART burst controls: mem_burst, mem_burst_wr, mem_burst_rd, mem_burst_end, mem_bw.
- Returns read data to the UART through dbg_dout/dbg_rd_rdy.

---
 rtl/dbg_mem_burst_ctl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dbg_mem_burst_ctl.sv
// Debug-UART memory access sequencer: owns MEM_CTL/ADDR/DATA/CNT
// and drives a single-master memory port with burst handshakes.
module dbg_mem_burst_ctl #(
  parameter logic [5:0] MEM_CTL_A  = 6'h05,
  parameter logic [5:0] MEM_ADDR_A = 6'h06,
  parameter logic [5:0] MEM_DATA_A = 6'h07,
  parameter logic [5:0] MEM_CNT_A  = 6'h08
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [5:0]  dbg_addr,
  input  logic [15:0] dbg_din,
  input  logic        dbg_wr,
  input  logic        dbg_rd,
  output logic [15:0] dbg_dout,
  output logic        dbg_rd_rdy,
  output logic        mem_burst,
  output logic        mem_burst_wr,
  output logic        mem_burst_rd,
  output logic        mem_burst_end,
  output logic        mem_bw,
  output logic        dbg_mem_en,
  output logic [1:0]  dbg_mem_wr,
  output logic [15:0] dbg_mem_addr,
  output logic [15:0] dbg_mem_dout,
  input  logic [15:0] dbg_mem_din,
  input  logic        dbg_mem_gnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RDAT,
    UPD
  } state_t;

  state_t state, state_nxt;

  logic        ctl_wr;
  logic        ctl_bw;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] mem_cnt;

  logic        busy;
  logic        reg_wr;
  logic        cnt_zero;
  logic        start;
  logic        trig_wr;
  logic        trig_rd;
  logic        trig;
  logic [15:0] rd_data;
  logic [15:0] reg_rdata;

  assign busy     = (state != IDLE) | mem_burst;
  assign reg_wr   = dbg_wr & ~busy;
  assign cnt_zero = (mem_cnt == 16'h0000);
  assign start    = reg_wr & (dbg_addr == MEM_CTL_A)
                  & dbg_din[0];

  // burst items only fire from IDLE; anything else is dropped
  assign trig_wr = (state == IDLE) & mem_burst
                 & ctl_wr & dbg_wr;
  assign trig_rd = (state == IDLE) & mem_burst
                 & ~ctl_wr & dbg_rd;
  assign trig    = (start & cnt_zero) | trig_wr | trig_rd;

  assign rd_data = ctl_bw
    ? {8'h00, mem_addr[0] ? dbg_mem_din[15:8]
                          : dbg_mem_din[7:0]}
    : dbg_mem_din;

  always_comb begin
    reg_rdata = 16'h0000;
    case (dbg_addr)
      MEM_CTL_A:  reg_rdata = {12'h000, ctl_bw, 1'b0,
                               ctl_wr, busy};
      MEM_ADDR_A: reg_rdata = mem_addr;
      MEM_DATA_A: reg_rdata = mem_data;
      MEM_CNT_A:  reg_rdata = mem_cnt;
      default:    reg_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (trig) state_nxt = REQ;
      REQ:  if (dbg_mem_gnt)
              state_nxt = ctl_wr ? UPD : RDAT;
      RDAT: state_nxt = UPD;
      UPD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_mem_en    = (state == REQ);
  assign mem_bw        = ctl_bw;
  assign mem_burst_end = mem_burst & ctl_wr & cnt_zero;

  // word accesses are always even-aligned on the bus
  assign dbg_mem_addr = ctl_bw ? mem_addr
                               : {mem_addr[15:1], 1'b0};
  assign dbg_mem_dout = ctl_bw
    ? {mem_data[7:0], mem_data[7:0]}
    : mem_data;

  always_comb begin
    dbg_mem_wr = 2'b00;
    if (dbg_mem_en && ctl_wr) begin
      if (!ctl_bw)          dbg_mem_wr = 2'b11;
      else if (mem_addr[0]) dbg_mem_wr = 2'b10;
      else                  dbg_mem_wr = 2'b01;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ctl_wr       <= 1'b0;
      ctl_bw       <= 1'b0;
      mem_addr     <= 16'h0000;
      mem_data     <= 16'h0000;
      mem_cnt      <= 16'h0000;
      mem_burst    <= 1'b0;
      mem_burst_wr <= 1'b0;
      mem_burst_rd <= 1'b0;
      dbg_dout     <= 16'h0000;
      dbg_rd_rdy   <= 1'b0;
    end else begin
      mem_burst_wr <= 1'b0;
      mem_burst_rd <= 1'b0;
      dbg_rd_rdy   <= 1'b0;
      if (reg_wr) begin
        case (dbg_addr)
          MEM_CTL_A: begin
            ctl_wr <= dbg_din[1];
            ctl_bw <= dbg_din[3];
            if (dbg_din[0] && !cnt_zero) begin
              mem_burst    <= 1'b1;
              mem_burst_wr <= dbg_din[1];
              mem_burst_rd <= ~dbg_din[1];
            end
          end
          MEM_ADDR_A: mem_addr <= dbg_din;
          MEM_DATA_A: mem_data <= dbg_din;
          MEM_CNT_A:  mem_cnt  <= dbg_din;
          default: ;
        endcase
      end
      if (dbg_rd && !mem_burst) begin
        dbg_dout   <= reg_rdata;
        dbg_rd_rdy <= 1'b1;
      end
      if (trig_wr) mem_data <= dbg_din;
      if (state == RDAT) begin
        mem_data <= rd_data;
        if (mem_burst) begin
          dbg_dout   <= rd_data;
          dbg_rd_rdy <= 1'b1;
        end
      end
      if (state == UPD) begin
        mem_addr <= mem_addr
                  + (ctl_bw ? 16'd1 : 16'd2);
        if (!cnt_zero) mem_cnt <= mem_cnt - 16'd1;
        else           mem_burst <= 1'b0;
      end
    end
  end

endmodule
